id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode/register-read stage sitting directly downstream of the fetch stage (IF_ID). Consumes the registered InstrD.
//  Decodes the 19-bit instruction and reads a 16x19 register file, which is written back from WB.
//  Resolves BEQ/JMP in decode and drives BranchD/PCBranch_Addr back to fetch.
//  Registers control and operands into the ID/EX pipeline register for execute.
// PARAMETERS
//  DATA_W  19  register/operand width
//  NREG    16  architectural registers; R0 reads 0, writes to it are dropped
//  ADDR_W  8   instruction address width
// PORTS
//  clk            in   1        rising-edge clock
//  rst            in   1        synchronous, active-high reset
//  InstrD         in   19       instruction from fetch pipeline register
//  RegWriteW      in   1        WB register write enable
//  WriteRegW      in   4        WB destination register
//  ResultW        in   19       WB write data
//  BranchD        out  1        comb: redirect fetch this cycle
//  PCBranch_Addr  out  8        comb: redirect target = InstrD[7:0]
//  RegWriteE      out  1        reg: EX instr writes a register
//  MemReadE       out  1        reg: EX instr is LD
//  MemWriteE      out  1        reg: EX instr is ST
//  ALUCtrlE       out  3        reg: 000 pass/add, 001 sub, 010 and, 011 or, 100 xor
//  RD1E, RD2E     out  19 each  reg: operands (R[rs1], R[rs2])
//  WriteRegE      out  4        reg: destination rd
// BEHAVIOUR
//  - Instruction fields:
//    - op = [18:14], rd = [13:10], rs1 = [9:6], rs2 = [5:2], imm8 = [7:0].
//  - Opcodes:
//    - 00000 NOP; 00001 ADD; 00010 SUB; 00011 AND; 00100 OR; 00101 XOR.
//    - 00110 LD: rd <= mem[R[rs1]]. 00111 ST: mem[R[rs1]] <= R[rd]; for ST, RD2E carries R[rd].
//    - 01000 BEQ: taken if R[rd] == R[rs1]. 01001 JMP: always taken.
//    - All other opcodes decode as NOP.
//  - Register file:
//    - Written at posedge when RegWriteW=1 and WriteRegW!=0.
//    - Reads are combinational; the R0 read is forced to 0.
//  - BranchD = ~squash_q & (JMP | (BEQ & equal)); PCBranch_Addr = imm8 whenever BranchD=1, else 0.
//  - Squash:
//    - The instruction fetched in the cycle BranchD=1 is wrong-path.
//    - squash_q <= BranchD at each posedge.
//    - While squash_q=1: InstrD is treated as NOP; BranchD=0; a bubble enters ID/EX.
//    - A squashed branch never redirects. Back-to-back branches: only the first is honoured.
//  - ID/EX register:
//    - Loads every cycle; no stall input; latency 1 cycle from InstrD to *E outputs.
//    - BEQ/JMP/NOP/illegal/squashed instructions load a bubble: all control 0; RD1E/RD2E/WriteRegE = 0.
//    - Write to rd=0 → RegWriteE=0.
//  - Reset (rst=1 at posedge):
//    - All *E outputs 0, squash_q=0, register file cleared to 0.
//    - rst asserted mid-stream discards the in-flight ID/EX contents.
//    - While rst=1, BranchD is forced to 0.
//  - Simultaneous WB write and decode read of the same register: result is set by WB_BYPASS_EN (see CONFIGURATION).
//  - The BEQ comparison uses the same read path as the operands, so it is also subject to WB_BYPASS_EN.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    - Write-through bypass: a read of register r returns ResultW when RegWriteW=1, WriteRegW==r and r!=0.
//    - Applies to RD1E, RD2E and the BEQ compare.
//  WB_BYPASS_EN undefined:
//    - Reads return the pre-write value.
//    - Software must place an extra NOP between producer and consumer.
// TESTING
//  1. Reset: hold rst 2 cycles, then InstrD=NOP -> all *E=0, BranchD=0, R1..R15 read 0.
//  2. WB R3=0x00055, then ADD rd=4, rs1=3, rs2=0 -> next cycle RD1E=0x00055, RD2E=0, ALUCtrlE=000, RegWriteE=1, WriteRegE=4.
//  3. JMP imm8=0x2A -> BranchD=1, PCBranch_Addr=0x2A same cycle; next InstrD (any ADD) squashed: RegWriteE=0, BranchD=0.
//  4. R1=R2=7, BEQ rd=1, rs1=2, imm8=0x10 -> taken; R2=8 -> BranchD=0, bubble to EX.
//  5. Same cycle WB R5=0x7FFFF and decode SUB rs1=5 -> RD1E=0x7FFFF with WB_BYPASS_EN, old value without it.
//  6. WB to R0 with 0x1234, then read rs1=0 -> RD1E=0; rst mid-stream with ST in ID -> MemWriteE=0 next cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode / register-read stage with ID/EX pipeline register; BEQ/JMP resolved here.
// Latency: BranchD/PCBranch_Addr combinational, *E outputs 1 cycle after InstrD.
// No backpressure: ID/EX loads every cycle. Optional macro WB_BYPASS_EN enables WB write-through reads.
module id_ex_stage #(
  parameter int DATA_W = 19,
  parameter int NREG   = 16,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       InstrD,
  input  logic                    RegWriteW,
  input  logic [$clog2(NREG)-1:0] WriteRegW,
  input  logic [DATA_W-1:0]       ResultW,
  output logic                    BranchD,
  output logic [ADDR_W-1:0]       PCBranch_Addr,
  output logic                    RegWriteE,
  output logic                    MemReadE,
  output logic                    MemWriteE,
  output logic [2:0]              ALUCtrlE,
  output logic [DATA_W-1:0]       RD1E,
  output logic [DATA_W-1:0]       RD2E,
  output logic [$clog2(NREG)-1:0] WriteRegE
);
  localparam int RA_W = $clog2(NREG);

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;
  localparam logic [4:0] OP_LD  = 5'd6;
  localparam logic [4:0] OP_ST  = 5'd7;
  localparam logic [4:0] OP_BEQ = 5'd8;
  localparam logic [4:0] OP_JMP = 5'd9;

  // instruction fields
  logic [4:0]        op;
  logic [RA_W-1:0]   rd, rs1, rs2;
  logic [ADDR_W-1:0] imm8;
  assign op   = InstrD[18:14];
  assign rd   = InstrD[13:10];
  assign rs1  = InstrD[9:6];
  assign rs2  = InstrD[5:2];
  assign imm8 = InstrD[7:0];

  logic [DATA_W-1:0] rf [NREG];
  logic              squash_q;

  // Second read port serves rd for ST data and the BEQ compare, else rs2.
  logic [RA_W-1:0]   ra2;
  logic [DATA_W-1:0] rdata1, rdata2;
  assign ra2 = (op == OP_ST || op == OP_BEQ) ? rd : rs2;

  // Combinational register reads; R0 is hardwired to zero.
  always_comb begin
    rdata1 = (rs1 == '0) ? '0 : rf[rs1];
    rdata2 = (ra2 == '0) ? '0 : rf[ra2];
`ifdef WB_BYPASS_EN
    if (RegWriteW && WriteRegW != '0 && WriteRegW == rs1) rdata1 = ResultW;
    if (RegWriteW && WriteRegW != '0 && WriteRegW == ra2) rdata2 = ResultW;
`endif
  end

  // Decode next ID/EX contents and the branch redirect; squashed slots become bubbles.
  logic              nx_regwrite, nx_memread, nx_memwrite;
  logic [2:0]        nx_alu;
  logic [DATA_W-1:0] nx_rd1, nx_rd2;
  logic [RA_W-1:0]   nx_wreg;
  always_comb begin
    nx_regwrite   = 1'b0;
    nx_memread    = 1'b0;
    nx_memwrite   = 1'b0;
    nx_alu        = 3'b000;
    nx_rd1        = '0;
    nx_rd2        = '0;
    nx_wreg       = '0;
    BranchD       = 1'b0;
    PCBranch_Addr = '0;
    if (!squash_q && !rst) begin
      case (op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LD: begin
          nx_regwrite = (rd != '0);
          nx_memread  = (op == OP_LD);
          nx_alu      = (op == OP_LD) ? 3'b000 : 3'(op - 5'd1);
          nx_rd1      = rdata1;
          nx_rd2      = rdata2;
          nx_wreg     = rd;
        end
        OP_ST: begin
          nx_memwrite = 1'b1;
          nx_rd1      = rdata1;
          nx_rd2      = rdata2;
          nx_wreg     = rd;
        end
        OP_BEQ: BranchD = (rdata2 == rdata1);
        OP_JMP: BranchD = 1'b1;
        default: ;
      endcase
      if (BranchD) PCBranch_Addr = imm8;
    end
  end

  // Register file write-back; reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (RegWriteW && WriteRegW != '0) begin
      rf[WriteRegW] <= ResultW;
    end
  end

  // ID/EX pipeline register and wrong-path squash flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      squash_q  <= 1'b0;
      RegWriteE <= 1'b0;
      MemReadE  <= 1'b0;
      MemWriteE <= 1'b0;
      ALUCtrlE  <= 3'b000;
      RD1E      <= '0;
      RD2E      <= '0;
      WriteRegE <= '0;
    end else begin
      squash_q  <= BranchD;
      RegWriteE <= nx_regwrite;
      MemReadE  <= nx_memread;
      MemWriteE <= nx_memwrite;
      ALUCtrlE  <= nx_alu;
      RD1E      <= nx_rd1;
      RD2E      <= nx_rd2;
      WriteRegE <= nx_wreg;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed cases then randomized traffic vs a behavioural model.
// Branch outputs checked late in each cycle, *E outputs checked just after the following edge.
// Stimulus pushes expectations; monitors pop and compare independently.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] InstrD = '0;
  logic        RegWriteW = 1'b0;
  logic [3:0]  WriteRegW = '0;
  logic [18:0] ResultW = '0;
  logic        BranchD;
  logic [7:0]  PCBranch_Addr;
  logic        RegWriteE, MemReadE, MemWriteE;
  logic [2:0]  ALUCtrlE;
  logic [18:0] RD1E, RD2E;
  logic [3:0]  WriteRegE;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .RegWriteW(RegWriteW),
    .WriteRegW(WriteRegW), .ResultW(ResultW), .BranchD(BranchD),
    .PCBranch_Addr(PCBranch_Addr), .RegWriteE(RegWriteE), .MemReadE(MemReadE),
    .MemWriteE(MemWriteE), .ALUCtrlE(ALUCtrlE), .RD1E(RD1E), .RD2E(RD2E),
    .WriteRegE(WriteRegE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw, mr, mw;
    logic [2:0]  alu;
    logic [18:0] rd1, rd2;
    logic [3:0]  wr;
  } e_t;
  typedef struct packed {
    logic       b;
    logic [7:0] a;
  } br_t;

  e_t  eq[$];
  br_t bq[$];
  int  n_chk = 0;
  int  n_fail = 0;

  // Reference state: architectural registers and "previous cycle redirected".
  logic [18:0] mregs [16];
  logic        msq = 1'b0;

  function automatic logic [18:0] mread(input logic [3:0] a, input logic rw,
                                        input logic [3:0] wr, input logic [18:0] res);
    if (a == 0) return '0;
`ifdef WB_BYPASS_EN
    if (rw && wr == a) return res;
`endif
    return mregs[a];
  endfunction

  function automatic logic [18:0] mk(input int op, input int rd, input int rs1, input int rs2);
    logic [18:0] w;
    w = '0;
    w[18:14] = 5'(op); w[13:10] = 4'(rd); w[9:6] = 4'(rs1); w[5:2] = 4'(rs2);
    return w;
  endfunction

  task automatic step(input logic r, input logic [18:0] ins, input logic rw,
                      input logic [3:0] wr, input logic [18:0] res);
    int op, rd, rs1, rs2;
    e_t  e;
    br_t b;
    @(negedge clk);
    rst = r; InstrD = ins; RegWriteW = rw; WriteRegW = wr; ResultW = res;
    op = int'(ins[18:14]); rd = int'(ins[13:10]); rs1 = int'(ins[9:6]); rs2 = int'(ins[5:2]);
    e = '0; b = '0;
    if (!r && !msq) begin
      if (op == 9) b.b = 1'b1;
      if (op == 8) b.b = (mread(4'(rd), rw, wr, res) == mread(4'(rs1), rw, wr, res));
      if (b.b) b.a = ins[7:0];
      if (op >= 1 && op <= 7) begin
        e.rd1 = mread(4'(rs1), rw, wr, res);
        e.rd2 = mread(4'(op == 7 ? rd : rs2), rw, wr, res);
        e.wr  = 4'(rd);
        e.rw  = (op != 7) && (rd != 0);
        e.mr  = (op == 6);
        e.mw  = (op == 7);
        e.alu = (op <= 5) ? 3'(op - 1) : 3'd0;
      end
    end
    bq.push_back(b);
    eq.push_back(e);
    msq = r ? 1'b0 : b.b;
    if (r) for (int i = 0; i < 16; i++) mregs[i] = '0;
    else if (rw && wr != 0) mregs[wr] = res;
  endtask

  // Branch monitor: combinational outputs sampled late in the low phase.
  initial forever begin
    @(negedge clk); #3;
    if (bq.size() != 0) begin
      br_t x;
      x = bq.pop_front();
      n_chk++;
      if ({BranchD, PCBranch_Addr} !== x) begin
        n_fail++;
        $display("FAIL branch t=%0t got BranchD=%b addr=%h exp BranchD=%b addr=%h",
                 $time, BranchD, PCBranch_Addr, x.b, x.a);
      end
    end
  end

  // ID/EX monitor: registered outputs sampled just after the rising edge.
  initial forever begin
    @(posedge clk); #1;
    if (eq.size() != 0) begin
      e_t x, g;
      x = eq.pop_front();
      g = {RegWriteE, MemReadE, MemWriteE, ALUCtrlE, RD1E, RD2E, WriteRegE};
      n_chk++;
      if (g !== x) begin
        n_fail++;
        $display("FAIL idex t=%0t got rw=%b mr=%b mw=%b alu=%h rd1=%h rd2=%h wr=%h exp rw=%b mr=%b mw=%b alu=%h rd1=%h rd2=%h wr=%h",
                 $time, g.rw, g.mr, g.mw, g.alu, g.rd1, g.rd2, g.wr,
                 x.rw, x.mr, x.mw, x.alu, x.rd1, x.rd2, x.wr);
      end
    end
  end

  initial begin
    logic [18:0] ins;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    // reset, then NOP and reads of every register
    step(1, '0, 0, 0, '0);
    step(1, '0, 0, 0, '0);
    step(0, '0, 0, 0, '0);
    for (int i = 1; i < 16; i++) step(0, mk(1, 1, i, 16 - i), 0, 0, '0);
    // WB R3 then ADD rd=4 rs1=3 rs2=0
    step(0, '0, 1, 3, 19'h00055);
    step(0, mk(1, 4, 3, 0), 0, 0, '0);
    // JMP 0x2A then a squashed ADD
    ins = mk(9, 0, 0, 0); ins[7:0] = 8'h2A;
    step(0, ins, 0, 0, '0);
    step(0, mk(1, 4, 3, 3), 0, 0, '0);
    step(0, '0, 0, 0, '0);
    // BEQ taken, then not taken after R2 changes; back-to-back branches
    step(0, '0, 1, 1, 19'd7);
    step(0, '0, 1, 2, 19'd7);
    step(0, mk(8, 1, 2, 4), 0, 0, '0);
    step(0, mk(8, 1, 2, 4), 0, 0, '0);
    step(0, '0, 1, 2, 19'd8);
    step(0, mk(8, 1, 2, 4), 0, 0, '0);
    step(0, mk(9, 0, 0, 5), 0, 0, '0);
    step(0, mk(9, 0, 0, 6), 0, 0, '0);
    // same-cycle WB and read of R5
    step(0, '0, 1, 5, 19'h00123);
    step(0, mk(2, 6, 5, 5), 1, 5, 19'h7FFFF);
    step(0, mk(2, 6, 5, 5), 0, 0, '0);
    // BEQ compare through the same-cycle write path
    step(0, mk(8, 5, 1, 0), 1, 5, 19'd7);
    step(0, '0, 0, 0, '0);
    // write to R0 dropped; LD/ST/logic ops; reset with ST in decode
    step(0, '0, 1, 0, 19'h01234);
    step(0, mk(1, 7, 0, 0), 0, 0, '0);
    step(0, mk(6, 8, 3, 2), 0, 0, '0);
    step(0, mk(7, 5, 3, 1), 0, 0, '0);
    step(0, mk(3, 0, 5, 3), 0, 0, '0);
    step(0, mk(4, 9, 5, 3), 0, 0, '0);
    step(0, mk(5, 10, 5, 3), 0, 0, '0);
    step(0, mk(7, 5, 3, 1), 0, 0, '0);
    step(1, mk(7, 5, 3, 1), 0, 0, '0);
    step(0, mk(1, 2, 3, 5), 0, 0, '0);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      ins = 19'($urandom);
      ins[18:14] = 5'($urandom_range(0, 12));
      step(($urandom_range(0, 49) == 0), ins, 1'($urandom), 4'($urandom), 19'($urandom));
    end
    step(0, '0, 0, 0, '0);
    repeat (3) @(negedge clk);
    if (eq.size() != 0 || bq.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d/%0d entries left exp 0/0", eq.size(), bq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
